// File: rtl/sort4_seq_ctrl_if.sv
// Valid/ready stream pair for the 4-word sorter.
// Upstream words come in on in_*; sorted words go out on out_*.
interface sort4_seq_ctrl_if #(
    parameter int DW = 8
) ();
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    // master: the producer/consumer side; slave: the sorter
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/sort4_seq_ctrl.sv
// Sequential 4-word sorter: one shared min/max comparator is stepped through
// a fixed 5-stage compare-exchange network, then words stream out ascending.

module comparator #(
    parameter int DW = 8
) (
    input  logic [DW-1:0] inp1,
    input  logic [DW-1:0] inp2,
    output logic [DW-1:0] out_min,
    output logic [DW-1:0] out_max
);
    always_comb begin
        if (inp1 <= inp2) begin
            out_min = inp1;
            out_max = inp2;
        end else begin
            out_min = inp2;
            out_max = inp1;
        end
    end
endmodule

// state | meaning
// LOAD  | accept four words into r0..r3 (idx selects the slot)
// SORT  | five compare-exchange steps, one per cycle (st selects the pair)
// OUT   | present r[idx] ascending, advance on each accepted beat
module sort4_seq_ctrl #(
    parameter int DW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    sort4_seq_ctrl_if.slave      bus,
    output logic                 busy,
    output logic [15:0]          sort_count
);
    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SORT = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t        state;
    logic [1:0]    idx;
    logic [2:0]    st;
    logic [DW-1:0] r [4];

    logic [1:0]    sel_a;
    logic [1:0]    sel_b;
    logic [1:0]    idx_nxt;
    logic [DW-1:0] cmp_min;
    logic [DW-1:0] cmp_max;

    logic          out_valid_q;
    logic          out_last_q;
    logic [DW-1:0] out_data_q;

    // Network (0,1)(2,3)(0,2)(1,3)(1,2) sorts any 4 inputs ascending
    always_comb begin
        sel_a = 2'd0;
        sel_b = 2'd1;
        case (st)
            3'd0: begin sel_a = 2'd0; sel_b = 2'd1; end
            3'd1: begin sel_a = 2'd2; sel_b = 2'd3; end
            3'd2: begin sel_a = 2'd0; sel_b = 2'd2; end
            3'd3: begin sel_a = 2'd1; sel_b = 2'd3; end
            default: begin sel_a = 2'd1; sel_b = 2'd2; end
        endcase
    end

    comparator #(.DW(DW)) u_cmp (
        .inp1    (r[sel_a]),
        .inp2    (r[sel_b]),
        .out_min (cmp_min),
        .out_max (cmp_max)
    );

    assign idx_nxt       = idx + 2'd1;
    assign bus.in_ready  = (state == LOAD) && !rst;
    assign busy          = (state != LOAD);
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_data  = out_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LOAD;
            idx         <= 2'd0;
            st          <= 3'd0;
            sort_count  <= 16'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                r[i] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    if (bus.in_valid) begin
                        r[idx] <= bus.in_data;
                        if (idx == 2'd3) begin
                            idx   <= 2'd0;
                            st    <= 3'd0;
                            state <= SORT;
                        end else begin
                            idx <= idx_nxt;
                        end
                    end
                end
                SORT: begin
                    r[sel_a] <= cmp_min;
                    r[sel_b] <= cmp_max;
                    if (st == 3'd4) begin
                        // r0 is already final once step 2 has run
                        state       <= OUT;
                        idx         <= 2'd0;
                        st          <= 3'd0;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        out_data_q  <= r[0];
                    end else begin
                        st <= st + 3'd1;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        if (idx == 2'd3) begin
                            idx         <= 2'd0;
                            sort_count  <= sort_count + 16'd1;
                            state       <= LOAD;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                        end else begin
                            idx        <= idx_nxt;
                            out_data_q <= r[idx_nxt];
                            out_last_q <= (idx == 2'd2);
                        end
                    end
                end
                default: begin
                    state       <= LOAD;
                    idx         <= 2'd0;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule
